// File: rtl/spike_event_framer_if.sv
// AXI-stream style handshake bundle shared by the framer's spike input and framed output.
interface spike_event_framer_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/spike_event_framer.sv
// Frames spike events into a self-delimiting 32-bit stream: one event word per spike
// and one trailer word (timestamp + spike count) closing every time step.
module spike_event_framer #(
    parameter int ID_W       = 16,
    parameter int TS_W       = 14,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    spike_event_framer_if.slave           s_axis,
    spike_event_framer_if.master          m_axis,
    input  logic                          step_end,
    output logic [TS_W-1:0]               cur_ts,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

    function automatic logic [31:0] event_word(input logic [ID_W-1:0] id);
        event_word = {2'b01, 30'(id)};
    endfunction

    function automatic logic [31:0] trailer_word(input logic [TS_W-1:0] ts, input logic [15:0] cnt);
        trailer_word = {2'b11, 14'(ts), cnt};
    endfunction

    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [31:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [15:0]      count_q, count_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic             pend_q, pend_d;
    logic             tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [31:0]      tdata_q, tdata_d;

    logic [LVL_W-1:0] free_s, lvl_after_pop_s;
    logic             s_ready_s, accept_s, pop_s, empty_step_s;
    logic [15:0]      cnt_inc_s;
    logic [1:0]       n_push_s;
    logic [31:0]      w0_s, w1_s, head_s;

    // Step bookkeeping, FIFO writes and the next word presented on the output register.
    always_comb begin
        free_s       = DEPTH_L - level_q;
        s_ready_s    = (free_s >= LVL_W'(2)) && !pend_q && aresetn;
        accept_s     = s_axis.tvalid && s_ready_s;
        pop_s        = tvalid_q && m_axis.tready;
        cnt_inc_s    = (count_q == 16'hFFFF) ? 16'hFFFF : count_q + 16'd1;
        empty_step_s = step_end && (count_q == 16'd0) && !accept_s && !pend_q;

        n_push_s = 2'd0;
        w0_s     = 32'd0;
        w1_s     = 32'd0;
        count_d  = count_q;
        ts_d     = ts_q;
        pend_d   = pend_q;

        if (accept_s) begin
            w0_s = event_word(s_axis.tdata[ID_W-1:0]);
            if (s_axis.tlast) begin
                w1_s     = trailer_word(ts_q, cnt_inc_s);
                n_push_s = 2'd2;
                count_d  = 16'd0;
                ts_d     = ts_q + TS_W'(1);
            end else begin
                n_push_s = 2'd1;
                count_d  = cnt_inc_s;
            end
        end else if (pend_q || empty_step_s) begin
            // Empty steps wait in pend until a slot opens; a deferred trailer keeps its timestamp.
            if (free_s >= LVL_W'(1)) begin
                w0_s     = trailer_word(ts_q, 16'd0);
                n_push_s = 2'd1;
                ts_d     = ts_q + TS_W'(1);
                pend_d   = 1'b0;
            end else begin
                pend_d   = 1'b1;
            end
        end else begin
            n_push_s = 2'd0;
        end

        mem_d = mem_q;
        if (n_push_s != 2'd0) begin
            mem_d[wr_ptr_q] = w0_s;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end
        if (n_push_s == 2'd2) begin
            mem_d[wr_ptr_q + PTR_W'(1)] = w1_s;
        end else begin
            mem_d[wr_ptr_q + PTR_W'(1)] = mem_q[wr_ptr_q + PTR_W'(1)];
        end

        wr_ptr_d        = wr_ptr_q + PTR_W'(n_push_s);
        rd_ptr_d        = rd_ptr_q + PTR_W'(pop_s);
        level_d         = level_q + LVL_W'(n_push_s) - LVL_W'(pop_s);
        lvl_after_pop_s = level_q - LVL_W'(pop_s);

        // When the FIFO drains to nothing, a word pushed this cycle goes straight to the head.
        if (lvl_after_pop_s != LVL_W'(0)) begin
            head_s = mem_q[rd_ptr_d];
        end else begin
            head_s = w0_s;
        end

        tvalid_d = (level_d != LVL_W'(0));
        tdata_d  = tvalid_d ? head_s : 32'd0;
        tlast_d  = tvalid_d && (head_s[31:30] == 2'b11);
    end

    // State registers; reset drops every buffered word and restarts the step timeline.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= 16'd0;
            ts_q     <= '0;
            pend_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= 32'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            count_q  <= count_d;
            ts_q     <= ts_d;
            pend_q   <= pend_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
        end
    end

    assign s_axis.tready = s_ready_s;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tlast  = tlast_q;
    assign cur_ts        = ts_q;
    assign fifo_level    = level_q;
endmodule

// File: tb/tb_spike_event_framer.sv
// Self-checking bench: table-driven step vectors plus hand-written backpressure, pend and reset sequences.
module tb_spike_event_framer;
    logic        aclk;
    logic        aresetn;
    logic        step_end;
    logic [13:0] cur_ts;
    logic [3:0]  fifo_level;

    spike_event_framer_if #(.DATA_W(16)) s_if ();
    spike_event_framer_if #(.DATA_W(32)) m_if ();

    spike_event_framer #(.ID_W(16), .TS_W(14), .FIFO_DEPTH(8)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .step_end   (step_end),
        .cur_ts     (cur_ts),
        .fifo_level (fifo_level)
    );

    typedef struct {
        logic        v;
        logic [15:0] id;
        logic        last;
        logic        step;
        int          n_exp;
        logic [32:0] e0;
        logic [32:0] e1;
        logic [13:0] ts;
        int          gap;
    } vec_t;

    vec_t        vecs [9];
    logic [32:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [13:0] model_ts;
    logic [15:0] model_cnt;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Scoreboard: every completed output handshake must match the oldest expected word.
    always @(negedge aclk) begin
        if (aresetn && m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", {m_if.tlast, m_if.tdata}, 33'd0);
            end else begin
                check("sb_word", {m_if.tlast, m_if.tdata}, exp_q.pop_front());
            end
        end
    end

    task automatic send_beat(input logic [15:0] id, input logic last);
        int n = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = id;
        s_if.tlast  = last;
        while (!s_if.tready && n < 300) begin
            tick();
            n++;
        end
        check("beat_accept_timeout", {32'd0, s_if.tready}, 33'd1);
        exp_q.push_back({1'b0, 2'b01, 14'd0, id});
        model_cnt = (model_cnt == 16'hFFFF) ? 16'hFFFF : model_cnt + 16'd1;
        if (last) begin
            exp_q.push_back({1'b1, 2'b11, model_ts, model_cnt});
            model_ts  = model_ts + 14'd1;
            model_cnt = 16'd0;
        end
        tick();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        m_if.tready = 1'b1;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        check("drain_left", {1'b0, 32'(exp_q.size())}, 33'd0);
        tick();
        check("drain_idle_valid", {32'd0, m_if.tvalid}, 33'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 16'd5,      1'b0, 1'b0, 1, {1'b0, 32'h40000005}, 33'd0, 14'd0, 0};
        vecs[1] = '{1'b1, 16'd9,      1'b0, 1'b0, 1, {1'b0, 32'h40000009}, 33'd0, 14'd0, 0};
        vecs[2] = '{1'b1, 16'd12,     1'b1, 1'b0, 2, {1'b0, 32'h4000000C}, {1'b1, 32'hC0000003}, 14'd1, 3};
        vecs[3] = '{1'b0, 16'd0,      1'b0, 1'b1, 1, {1'b1, 32'hC0010000}, 33'd0, 14'd2, 10};
        vecs[4] = '{1'b0, 16'd0,      1'b0, 1'b1, 1, {1'b1, 32'hC0020000}, 33'd0, 14'd3, 2};
        vecs[5] = '{1'b1, 16'd7,      1'b1, 1'b1, 2, {1'b0, 32'h40000007}, {1'b1, 32'hC0030001}, 14'd4, 2};
        vecs[6] = '{1'b1, 16'd3,      1'b0, 1'b1, 1, {1'b0, 32'h40000003}, 33'd0, 14'd4, 2};
        vecs[7] = '{1'b0, 16'd0,      1'b0, 1'b1, 0, 33'd0, 33'd0, 14'd4, 2};
        vecs[8] = '{1'b1, 16'hFFFF,   1'b1, 1'b0, 2, {1'b0, 32'h4000FFFF}, {1'b1, 32'hC0040002}, 14'd5, 2};

        aresetn     = 1'b0;
        step_end    = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 16'd0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        model_ts    = 14'd0;
        model_cnt   = 16'd0;
        #22;
        check("rst_m_tvalid", {32'd0, m_if.tvalid}, 33'd0);
        check("rst_m_tdata", {1'b0, m_if.tdata}, 33'd0);
        check("rst_m_tlast", {32'd0, m_if.tlast}, 33'd0);
        check("rst_s_tready", {32'd0, s_if.tready}, 33'd0);
        check("rst_cur_ts", {19'd0, cur_ts}, 33'd0);
        check("rst_level", {29'd0, fifo_level}, 33'd0);
        tick();
        aresetn = 1'b1;
        tick();

        // Basic framing, empty steps, and step_end coinciding with beats.
        for (int i = 0; i < 9; i++) begin
            s_if.tvalid = vecs[i].v;
            s_if.tdata  = vecs[i].id;
            s_if.tlast  = vecs[i].last;
            step_end    = vecs[i].step;
            if (vecs[i].v) check("vec_tready", {32'd0, s_if.tready}, 33'd1);
            if (vecs[i].n_exp >= 1) exp_q.push_back(vecs[i].e0);
            if (vecs[i].n_exp == 2) exp_q.push_back(vecs[i].e1);
            tick();
            s_if.tvalid = 1'b0;
            s_if.tlast  = 1'b0;
            step_end    = 1'b0;
            check("vec_cur_ts", {19'd0, cur_ts}, {19'd0, vecs[i].ts});
            repeat (vecs[i].gap) tick();
        end
        drain();
        model_ts  = 14'd5;
        model_cnt = 16'd0;

        // Backpressure: 20 beats with the sink stalled, then released mid-stream.
        m_if.tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 7) begin
                s_if.tvalid = 1'b1;
                s_if.tdata  = 16'd107;
                tick();
                tick();
                check("t3_tready_full", {32'd0, s_if.tready}, 33'd0);
                check("t3_level", {29'd0, fifo_level}, 33'd7);
                check("t3_hold_data", {1'b0, m_if.tdata}, {1'b0, 32'h40000064});
                m_if.tready = 1'b1;
            end
            send_beat(16'(100 + i), i == 19);
        end
        drain();
        check("t3_cur_ts", {19'd0, cur_ts}, 33'd6);

        // Full FIFO plus an empty step: trailer deferred until a slot opens.
        m_if.tready = 1'b0;
        for (int i = 1; i <= 4; i++) send_beat(16'(i), 1'b1);
        check("t5_level_full", {29'd0, fifo_level}, 33'd8);
        check("t5_tready_full", {32'd0, s_if.tready}, 33'd0);
        step_end = 1'b1;
        exp_q.push_back({1'b1, 2'b11, model_ts, 16'd0});
        model_ts = model_ts + 14'd1;
        tick();
        step_end = 1'b0;
        check("t5_ts_pending", {19'd0, cur_ts}, 33'd10);
        tick();
        check("t5_tready_pend", {32'd0, s_if.tready}, 33'd0);
        m_if.tready = 1'b1;
        tick();
        check("t5_tready_after_pop", {32'd0, s_if.tready}, 33'd0);
        check("t5_ts_before_push", {19'd0, cur_ts}, 33'd10);
        tick();
        check("t5_ts_after_push", {19'd0, cur_ts}, 33'd11);
        begin
            int n = 0;
            while (!s_if.tready && n < 50) begin
                tick();
                n++;
            end
        end
        check("t5_tready_resume", {32'd0, s_if.tready}, 33'd1);
        drain();

        // Reset mid-step with four buffered events.
        m_if.tready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(16'(16'h21 + i), 1'b0);
        check("t6_level_before", {29'd0, fifo_level}, 33'd4);
        aresetn = 1'b0;
        #1;
        exp_q.delete();
        model_ts  = 14'd0;
        model_cnt = 16'd0;
        check("t6_m_tvalid", {32'd0, m_if.tvalid}, 33'd0);
        check("t6_level", {29'd0, fifo_level}, 33'd0);
        check("t6_cur_ts", {19'd0, cur_ts}, 33'd0);
        check("t6_s_tready", {32'd0, s_if.tready}, 33'd0);
        tick();
        tick();
        aresetn     = 1'b1;
        m_if.tready = 1'b1;
        tick();
        send_beat(16'h30, 1'b1);
        check("t6_ts_after", {19'd0, cur_ts}, 33'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
